apb_cmd_master: RTL

- APB master stage on the APB clock domain, directly downstream of the command async FIFO read port and upstream of the response async FIFO write port.
- Pops one command word per transfer, runs one APB transfer to one of NSLV slaves, and pushes {err, rdata} into the response FIFO for reads only.
- Drives the rdata_en and wdata_vld strobes that the FIFO pointer checks observe.

---
 rtl/apb_bridge_pkg.sv | 29 ++
 rtl/apb_slv_decode.sv | 27 ++
 rtl/apb_cmd_master.sv | 130 +++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types for the APB command master: FSM states, command and
// response word layouts, and default bus widths.
package apb_bridge_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                  err;
    logic [DEF_DATA_W-1:0] rdata;
  } rsp_t;

  localparam logic [DEF_DATA_W-1:0] ABORT_RDATA = '0;

endpackage

// File: rtl/apb_slv_decode.sv
// Address to one-hot slave select; every address bit above the slave
// field takes part in the range check.
module apb_slv_decode #(
  parameter int ADDR_W    = 32,
  parameter int NSLV      = 4,
  parameter int SLV_SHIFT = 12
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NSLV-1:0]   psel_o,
  output logic              oor_o
);

  localparam int IW = ADDR_W - SLV_SHIFT;

  logic [IW-1:0] idx;

  assign idx   = addr_i[ADDR_W-1:SLV_SHIFT];
  assign oor_o = (idx >= IW'(NSLV));

  always_comb begin
    psel_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == IW'(i)) psel_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB master stage: pops a command, runs one APB transfer, and pushes
// {err, rdata} to the response FIFO for reads.
module apb_cmd_master
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NSLV      = 4,
  parameter int SLV_SHIFT = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_empty,
  input  logic [ADDR_W+DATA_W:0]   cmd_rdata,
  output logic                     cmd_rd_en,
  input  logic                     rsp_full,
  output logic                     rsp_wdata_vld,
  output logic [DATA_W:0]          rsp_wdata,
  output logic [NSLV-1:0]          psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e            state_q;
  logic [NSLV-1:0]   psel_q;
  logic [NSLV-1:0]   dec_psel;
  logic              dec_oor;
  logic              oor_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  rsp_t              rsp_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  cmd_t              cmd_w;

  assign cmd_w = cmd_rdata;

  apb_slv_decode #(
    .ADDR_W    (ADDR_W),
    .NSLV      (NSLV),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_dec (
    .addr_i (cmd_w.addr),
    .psel_o (dec_psel),
    .oor_o  (dec_oor)
  );

  // Saturating wait-state count
  assign cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // FIFO strobes are combinational so a pop/push lands in the same cycle
  assign cmd_rd_en     = !rst && (state_q == IDLE) && !cmd_empty;
  assign rsp_wdata_vld = !rst && (state_q == RESP) && !rsp_full;

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_wdata = rsp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      oor_q     <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!cmd_empty) state_q <= FETCH;
        end
        FETCH: begin
          psel_q   <= dec_psel;
          oor_q    <= dec_oor;
          paddr_q  <= cmd_w.addr;
          pwrite_q <= cmd_w.write;
          pwdata_q <= cmd_w.write ? cmd_w.wdata : '0;
          state_q  <= SETUP;
        end
        SETUP: begin
          cnt_q <= '0;
          if (oor_q) begin
            rsp_q   <= '{err: 1'b1, rdata: ABORT_RDATA};
            state_q <= pwrite_q ? IDLE : RESP;
          end else begin
            penable_q <= 1'b1;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (pready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rsp_q     <= '{err: pslverr,
                           rdata: pwrite_q ? ABORT_RDATA : prdata};
            state_q   <= pwrite_q ? IDLE : RESP;
          end else if (cnt_d == TO) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rsp_q     <= '{err: 1'b1, rdata: ABORT_RDATA};
            state_q   <= pwrite_q ? IDLE : RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (!rsp_full) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
